sprite_mover: RTL
=================

SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 SHALL have parameter SCREEN_W, default 1024, meaning visible width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 768, meaning visible height in lines.
REQ-003 SHALL have parameter SPRITE_W, default 256, meaning sprite width.
REQ-004 SHALL have parameter SPRITE_H, default 256, meaning sprite height.
REQ-005 SHALL have parameter STEP, default 4, meaning pixels moved per frame.
REQ-006 SHALL have parameter DEBOUNCE_CYCLES, default 650000, meaning stable cycles before a button state is accepted.
REQ-007 SHALL have port pixel_clk_in, input, 1, meaning the only clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n_in, input, 1, meaning reset; asynchronous and active-low.
REQ-009 SHALL have port vsync_in, input, 1, meaning active-high vsync from the timing generator.
REQ-010 SHALL have port btn_in, input, 4, meaning raw asynchronous buttons {up,down,left,right}, bit 3 = up.
REQ-011 SHALL have port auto_in, input, 1, meaning 1 = bounce mode, 0 = manual mode.
REQ-012 SHALL have port x_out, output, 11, meaning sprite left edge, fed to the sprite address stage.
REQ-013 SHALL have port y_out, output, 10, meaning sprite top edge.
REQ-014 SHALL have port frame_out, output, 1, meaning one-cycle pulse on each position update.

Function
REQ-015 SHALL pass each btn_in bit through a 2-flop synchronizer, then an independent debouncer whose accepted state changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts that bit's counter at 0.
REQ-016 SHALL register vsync_in and generate frame tick = vsync_in & ~vsync_q (rising edge); frame_out SHALL be this tick delayed one cycle, coinciding with the new x_out/y_out.
REQ-017 SHALL update x_out/y_out only on frame tick; outputs held constant all other cycles, so the sprite never shifts mid-frame.
REQ-018 SHALL define XMAX = SCREEN_W-SPRITE_W (768) and YMAX = SCREEN_H-SPRITE_H (512); x_out SHALL stay in [0,XMAX] and y_out in [0,YMAX] at all times.
REQ-019 SHALL sample auto_in only at frame tick; a mid-frame change takes effect at the next tick.
REQ-020 Manual mode SHALL move x by -STEP (left) or +STEP (right), y by -STEP (up) or +STEP (down), per tick, for each debounced-pressed button.
REQ-021 Manual mode SHALL make no move on an axis when both opposing buttons are pressed; the other axis is unaffected.
REQ-022 Manual mode SHALL clamp saturating: x<STEP moving left -> 0; x+STEP>XMAX moving right -> XMAX; same for y; computed in widths one bit wider than the output, no wrap-around.
REQ-023 Bounce mode SHALL implement a 4-state direction FSM {DR, DL, UR, UL} (x dir, y dir); each tick, step both axes by STEP in current directions.
REQ-024 Bounce mode SHALL, when a step would cross a bound, land exactly on the bound (0 or MAX) and flip that axis's direction for the next tick; corner hit flips both axes in the same tick.
REQ-025 SHALL ignore buttons in bounce mode; manual mode SHALL leave the direction FSM unchanged.
REQ-026 On manual->bounce transition the FSM SHALL resume from its held state.

Reset
REQ-027 SHALL on rst_n_in low immediately force x_out=384 ((XMAX)/2), y_out=256 (YMAX/2), frame_out=0, FSM=DR, synchronizers, debounce counters and accepted states 0, vsync_q 0.
REQ-028 SHALL, on reset assertion mid-frame or mid-debounce, discard all partial state; first update after release requires a fresh vsync rising edge.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-029 Reset release, auto_in=0, no buttons, 3 vsync pulses -> x_out=384, y_out=256, three frame_out pulses each one cycle after vsync rise.
REQ-030 Right held (debounced), 2 frames -> x_out 384->388->392; 3-cycle glitch on left -> no x change.
REQ-031 x_out=766 manual, right held -> next tick x_out=768, further ticks remain 768; left+right held -> x unchanged while up moves y by -4.
REQ-032 auto_in=1 from reset: ticks give (388,260),(392,264)...; at y=508 tick -> y=512, next tick y=508 with FSM UR.
REQ-033 Bounce starting x=766,y=510 DR -> tick gives (768,512) FSM UL, next (764,508).
REQ-034 Assert rst_n_in for 1 cycle mid-frame with x=500 -> x_out=384 asynchronously, no frame_out until next vsync rise.

Source files
------------

// File: rtl/sprite_mover.sv
// Moves a sprite once per frame, either from debounced buttons or by bouncing off the screen edges.
// Latency: new x_out/y_out and the frame_out pulse appear one cycle after the vsync rising edge.
// Backpressure: none. Positions are always valid and are held between frame ticks.
module sprite_mover #(
  parameter int SCREEN_W        = 1024,
  parameter int SCREEN_H        = 768,
  parameter int SPRITE_W        = 256,
  parameter int SPRITE_H        = 256,
  parameter int STEP            = 4,
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        vsync_in,
  input  logic [3:0]  btn_in,
  input  logic        auto_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        frame_out
);

  localparam int XMAX = SCREEN_W - SPRITE_W;
  localparam int YMAX = SCREEN_H - SPRITE_H;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [11:0] XMAX_W = 12'(XMAX);
  localparam logic [10:0] YMAX_W = 11'(YMAX);
  localparam logic [11:0] STEP_X = 12'(STEP);
  localparam logic [10:0] STEP_Y = 11'(STEP);
  localparam logic [10:0] X_RST  = 11'(XMAX / 2);
  localparam logic [9:0]  Y_RST  = 10'(YMAX / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {DR, DL, UR, UL} dir_t;

  logic [3:0]  btn_meta, btn_sync, btn_db;
  logic        vsync_q, tick;
  dir_t        state, state_nxt;
  logic [10:0] x_nxt;
  logic [9:0]  y_nxt;
  logic        x_right, y_down, xr_nxt, yd_nxt;
  logic [11:0] x_inc;
  logic [10:0] y_inc;
  logic        x_inc_hit, x_dec_hit, y_inc_hit, y_dec_hit;
  logic [10:0] x_inc_val, x_dec_val;
  logic [9:0]  y_inc_val, y_dec_val;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      btn_meta <= '0;
      btn_sync <= '0;
      vsync_q  <= 1'b0;
    end else begin
      btn_meta <= btn_in;
      btn_sync <= btn_meta;
      vsync_q  <= vsync_in;
    end
  end

  // Any cycle where the synchronized input agrees with the accepted state restarts the count.
  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic          acc;
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        cnt <= '0;
        acc <= 1'b0;
      end else if (btn_sync[i] == acc) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        acc <= btn_sync[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign btn_db[i] = acc;
  end

  assign tick = vsync_in & ~vsync_q;

  // Saturating candidates computed one bit wide so the +STEP never wraps.
  assign x_inc     = {1'b0, x_out} + STEP_X;
  assign x_inc_hit = x_inc >= XMAX_W;
  assign x_inc_val = x_inc_hit ? XMAX_W[10:0] : x_inc[10:0];
  assign x_dec_hit = {1'b0, x_out} <= STEP_X;
  assign x_dec_val = x_dec_hit ? 11'd0 : x_out - STEP_X[10:0];

  assign y_inc     = {1'b0, y_out} + STEP_Y;
  assign y_inc_hit = y_inc >= YMAX_W;
  assign y_inc_val = y_inc_hit ? YMAX_W[9:0] : y_inc[9:0];
  assign y_dec_hit = {1'b0, y_out} <= STEP_Y;
  assign y_dec_val = y_dec_hit ? 10'd0 : y_out - STEP_Y[9:0];

  assign x_right = (state == DR) || (state == UR);
  assign y_down  = (state == DR) || (state == DL);

  always_comb begin
    state_nxt = state;
    x_nxt     = x_out;
    y_nxt     = y_out;
    xr_nxt    = x_right;
    yd_nxt    = y_down;
    if (tick) begin
      if (auto_in) begin
        if (x_right) begin
          x_nxt  = x_inc_val;
          xr_nxt = !x_inc_hit;
        end else begin
          x_nxt  = x_dec_val;
          xr_nxt = x_dec_hit;
        end
        if (y_down) begin
          y_nxt  = y_inc_val;
          yd_nxt = !y_inc_hit;
        end else begin
          y_nxt  = y_dec_val;
          yd_nxt = y_dec_hit;
        end
        state_nxt = yd_nxt ? (xr_nxt ? DR : DL) : (xr_nxt ? UR : UL);
      end else begin
        // btn_db = {up, down, left, right}; opposing pair cancels on that axis.
        if (btn_db[0] && !btn_db[1]) x_nxt = x_inc_val;
        else if (btn_db[1] && !btn_db[0]) x_nxt = x_dec_val;
        if (btn_db[2] && !btn_db[3]) y_nxt = y_inc_val;
        else if (btn_db[3] && !btn_db[2]) y_nxt = y_dec_val;
      end
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= DR;
      x_out     <= X_RST;
      y_out     <= Y_RST;
      frame_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      x_out     <= x_nxt;
      y_out     <= y_nxt;
      frame_out <= tick;
    end
  end

endmodule
